// File: rtl/stream_register_slice_if.sv
// Valid/ready stream bundle for stream_register_slice: upstream payload and
// handshake, downstream payload and handshake, flush control and occupancy.
interface stream_register_slice_if #(
  parameter int WIDTH = 16
);
  logic             i_flush;
  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             o_ready;
  logic [1:0]       o_count;

  // View of the slice itself.
  modport slave (
    input  i_flush, i_data, i_valid, o_ready,
    output i_ready, o_data, o_valid, o_count
  );

  // View of the surrounding producer/consumer.
  modport master (
    output i_flush, i_data, i_valid, o_ready,
    input  i_ready, o_data, o_valid, o_count
  );
endinterface

// File: rtl/stream_register_slice.sv
// Fully registered two-entry valid/ready pipeline stage. The main register
// drives o_data; the skid register absorbs the beat that is in flight when
// the downstream stalls. Every output is a flop, so neither valid/data nor
// ready has a combinational path through the block.
module stream_register_slice #(
  parameter int WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst,
  stream_register_slice_if.slave s
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             valid_q;
  logic             ready_q;
  logic [1:0]       count_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  logic in_xfer;
  logic out_xfer;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid_in;

  assign in_xfer  = s.i_valid && ready_q;
  assign out_xfer = valid_q && s.o_ready;

  // Next-state and register-load decisions; flush overrides everything.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (s.i_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            load_main_in = 1'b1;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            load_main_in = 1'b1;
          end else if (in_xfer) begin
            load_skid_in = 1'b1;
            state_d      = FULL;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // i_ready is low here, so only the output side can move.
          if (out_xfer) begin
            load_main_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and the output flags, each a flop decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != EMPTY);
      ready_q <= (state_d != FULL);
      count_q <= (state_d == FULL) ? 2'd2 : ((state_d == ONE) ? 2'd1 : 2'd0);
    end
  end

  // Payload registers; only written on an accepted or promoted beat.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the two data registers are reset to zero so o_data is defined
    // after reset; a deeper storage array would normally be left unreset.
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= s.i_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid_in) begin
        skid_q <= s.i_data;
      end
    end
  end

  assign s.o_data  = main_q;
  assign s.o_valid = valid_q;
  assign s.i_ready = ready_q;
  assign s.o_count = count_q;

endmodule

// File: doc/stream_register_slice.md
# stream_register_slice

Fully registered two-entry valid/ready pipeline stage for the VDP streaming datapath. It breaks both the forward path (valid/data) and the backward path (ready) with flops, so no combinational path crosses the block in either direction. It is placed wherever long routes or deep logic sit between a stream producer and consumer, such as the pixel fetch to line buffer path. It sustains one transfer per cycle with a fixed one-cycle forward latency.

## Interface
- WIDTH, 16, data bits per transfer
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- i_flush  in  1  synchronous discard of all held entries
- i_data  in  WIDTH  upstream payload
- i_valid  in  1  upstream offers i_data
- i_ready  out  1  slice can accept; driven directly by a flop
- o_data  out  WIDTH  downstream payload; driven directly by a flop
- o_valid  out  1  o_data is valid; driven directly by a flop
- o_ready  in  1  downstream accepts o_data
- o_count  out  2  entries currently held (0..2); driven directly by a flop

## Operation
- Storage consists of a main register, which drives o_data, and a skid register. The state machine has three states: EMPTY, ONE and FULL.
- An input transfer occurs when i_valid && i_ready. An output transfer occurs when o_valid && o_ready.
- Output flop values per state:
  - EMPTY: o_valid=0, i_ready=1, o_count=0.
  - ONE: o_valid=1, i_ready=1, o_count=1.
  - FULL: o_valid=1, i_ready=0, o_count=2.
- Transitions when i_flush=0:
  - EMPTY, with input: main<=i_data, go to ONE.
  - EMPTY, no input: stay in EMPTY.
  - ONE, input only: skid<=i_data, go to FULL.
  - ONE, output only: go to EMPTY.
  - ONE, input and output in the same cycle: main<=i_data, stay in ONE.
  - ONE, neither: hold.
  - FULL, with output: main<=skid, go to ONE. No input is possible because i_ready=0.
  - FULL, no output: hold. Main and skid are unchanged.
- i_flush=1 overrides everything in that cycle:
  - The next state is EMPTY.
  - Any input transfer in that cycle is dropped, even though upstream sees the handshake complete.
  - An output transfer in the same cycle still counts as delivered.
- Data order is strict FIFO. No entry is duplicated or lost except through flush.
- o_data must not change while o_valid=1 && o_ready=0.
- i_data and i_valid are ignored when i_ready=0.

## Timing
- Reset (async assert) forces:
  - state=EMPTY, o_valid=0, o_count=0
  - i_ready=0 while rst is high
  - main=0 and skid=0
- The first rising clk edge after rst deasserts sets i_ready=1. Upstream transfers are possible from the following cycle.
- Reset asserted mid-operation discards all entries immediately, with no clock edge needed.
- Forward latency: data accepted at edge N appears on o_data with o_valid=1 after edge N. It is transferable at edge N+1 at the earliest.
- Backpressure latency:
  - i_ready falls one edge after the slice reaches FULL. The second entry absorbs the in-flight beat.
  - i_ready rises one edge after FULL drains to ONE.
- Throughput: one transfer per cycle with o_ready held high and i_valid held high, in steady state ONE.
- Upstream may drop i_valid at any time. The slice never requires i_valid to be held.

## Test plan
- Reset release with i_valid=1, i_data=0x1111, o_ready=1:
  - o_valid=0 and i_ready=0 during reset; i_ready=1 after the first edge.
  - 0x1111 appears on o_data exactly one edge after acceptance.
- Streaming: 0x0001..0x0040 sent back-to-back with o_ready=1:
  - 64 outputs in order on 64 consecutive cycles.
  - o_count stays at 1.
- Stall: stream 0xA000.. with o_ready low for 5 cycles:
  - Exactly two beats are accepted, then i_ready=0 and o_count=2.
  - o_data holds 0xA000 steady.
  - On release, 0xA000 then 0xA001 then 0xA002 are delivered, with no loss or duplication.
- Random i_valid and o_ready at 50% each, 10k beats:
  - Scoreboard shows FIFO order.
  - o_count equals accepted minus delivered, within 0..2.
- i_flush while FULL holding 0xBEEF and 0xCAFE, with a simultaneous i_valid (0xDEAD) and o_ready=0:
  - Next cycle: o_valid=0, o_count=0.
  - 0xDEAD is never output.
- Async rst pulse shorter than one clock period while FULL:
  - o_valid=0 and o_count=0 immediately, before any edge.
  - Normal acceptance resumes one edge after release.
